// File: rtl/flt_pkg.sv
// Shared constants, state encoding and number format for the half-precision adder.
package flt_pkg;

   localparam int unsigned EXP_W     = 5;
   localparam int unsigned FRAC_W    = 10;
   localparam int unsigned BIAS      = 15;
   localparam int unsigned EXP_MAX   = 2 * BIAS + 1;
   localparam int unsigned MEM_DEPTH = 256;

   localparam logic [7:0] OP_A_ADDR = 8'd128;
   localparam logic [7:0] OP_B_ADDR = 8'd130;
   localparam logic [7:0] RES_ADDR  = 8'd132;

   typedef enum logic [3:0] {
      StIdle,
      StRdA0,
      StRdA1,
      StRdB0,
      StRdB1,
      StAlign,
      StAdd,
      StNorm,
      StWr0,
      StWr1,
      StDone
   } state_e;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp16_t;

   // Number of zeros above the leading one of an 11-bit mantissa (11 when zero).
   function automatic logic [3:0] lzc11(input logic [10:0] v);
      logic [3:0] n;
      n = 4'd11;
      for (int i = 0; i < 11; i++) begin
         if (v[i]) n = 4'(10 - i);
      end
      return n;
   endfunction

endpackage

// File: rtl/data_mem.sv
// Byte-wide data memory: synchronous write, combinational read, contents survive reset.
module data_mem
   import flt_pkg::*;
(
   input  logic       clk_i,
   input  logic       we_i,
   input  logic [7:0] addr_i,
   input  logic [7:0] wdata_i,
   output logic [7:0] rdata_o
);

   logic [7:0] my_memory [0:MEM_DEPTH-1];

   always_ff @(posedge clk_i) begin
      if (we_i) my_memory[addr_i] <= wdata_i;
   end

   assign rdata_o = my_memory[addr_i];

endmodule

// File: rtl/flt_flt.sv
// Standalone half-precision adder: reads two operands from its own memory, stores the sum.
module flt_flt
   import flt_pkg::*;
(
   input  logic clk,
   input  logic reset,
   output logic done
);

   state_e      state_q, state_d;
   fp16_t       a_q, a_d, b_q, b_d, res_q, res_d;
   logic        sign_q, sign_d, sub_q, sub_d, done_q, done_d;
   logic [4:0]  exp_q, exp_d;
   logic [10:0] big_q, big_d, sml_q, sml_d;
   logic [11:0] sum_q, sum_d;

   logic        mem_we;
   logic [7:0]  mem_addr, mem_wdata, mem_rdata;

   logic [4:0]  ea, eb, e_diff;
   logic [10:0] ma, mb, sml_raw, sml_sh;
   logic        a_big;
   logic [3:0]  lz;
   logic [5:0]  e_inc;
   logic [9:0]  norm_m;
   fp16_t       norm_res;

   data_mem data_mem1 (
      .clk_i  (clk),
      .we_i   (mem_we),
      .addr_i (mem_addr),
      .wdata_i(mem_wdata),
      .rdata_o(mem_rdata)
   );

   // Denormal inputs align as exponent 1 with a zero hidden bit.
   always_comb begin : p_align
      ea      = (a_q.exp == '0) ? 5'd1 : a_q.exp;
      eb      = (b_q.exp == '0) ? 5'd1 : b_q.exp;
      ma      = {(a_q.exp != '0), a_q.frac};
      mb      = {(b_q.exp != '0), b_q.frac};
      a_big   = {ea, ma} >= {eb, mb};
      e_diff  = a_big ? (ea - eb) : (eb - ea);
      sml_raw = a_big ? mb : ma;
      sml_sh  = (e_diff >= 5'd12) ? '0 : (sml_raw >> e_diff);
   end

   always_comb begin : p_norm
      lz       = lzc11(sum_q[10:0]);
      e_inc    = {1'b0, exp_q} + 6'd1;
      norm_m   = 10'(sum_q[10:0] << lz);
      norm_res = '0;
      if (sum_q == '0) begin
         norm_res = '0;
      end else if (!sub_q) begin
         if (sum_q[11]) begin
            if (e_inc > 6'(EXP_MAX)) norm_res = {sign_q, 5'h1f, 10'h3ff};
            else                     norm_res = {sign_q, e_inc[4:0], sum_q[10:1]};
         end else begin
            // Only two denormals can add without reaching the hidden bit.
            norm_res = {sign_q, (sum_q[10] ? exp_q : 5'd0), sum_q[9:0]};
         end
      end else if ({1'b0, exp_q} <= {2'b00, lz}) begin
         norm_res = '0;
      end else begin
         norm_res = {sign_q, exp_q - {1'b0, lz}, norm_m};
      end
   end

   always_comb begin : p_mem
      mem_we    = 1'b0;
      mem_addr  = OP_A_ADDR;
      mem_wdata = res_q[15:8];
      unique case (state_q)
         StRdA1:  mem_addr = OP_A_ADDR + 8'd1;
         StRdB0:  mem_addr = OP_B_ADDR;
         StRdB1:  mem_addr = OP_B_ADDR + 8'd1;
         StWr0: begin
            mem_we   = 1'b1;
            mem_addr = RES_ADDR;
         end
         StWr1: begin
            mem_we    = 1'b1;
            mem_addr  = RES_ADDR + 8'd1;
            mem_wdata = res_q[7:0];
         end
         default: ;
      endcase
   end

   always_comb begin : p_next
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sign_d  = sign_q;
      exp_d   = exp_q;
      big_d   = big_q;
      sml_d   = sml_q;
      sub_d   = sub_q;
      sum_d   = sum_q;
      res_d   = res_q;
      done_d  = done_q;
      unique case (state_q)
         StIdle: state_d = StRdA0;
         StRdA0: begin
            a_d[15:8] = mem_rdata;
            state_d   = StRdA1;
         end
         StRdA1: begin
            a_d[7:0] = mem_rdata;
            state_d  = StRdB0;
         end
         StRdB0: begin
            b_d[15:8] = mem_rdata;
            state_d   = StRdB1;
         end
         StRdB1: begin
            b_d[7:0] = mem_rdata;
            state_d  = StAlign;
         end
         StAlign: begin
            sign_d  = a_big ? a_q.sign : b_q.sign;
            exp_d   = a_big ? ea : eb;
            big_d   = a_big ? ma : mb;
            sml_d   = sml_sh;
            sub_d   = a_q.sign ^ b_q.sign;
            state_d = StAdd;
         end
         StAdd: begin
            sum_d   = sub_q ? ({1'b0, big_q} - {1'b0, sml_q}) : ({1'b0, big_q} + {1'b0, sml_q});
            state_d = StNorm;
         end
         StNorm: begin
            res_d   = norm_res;
            state_d = StWr0;
         end
         StWr0: state_d = StWr1;
         StWr1: begin
            done_d  = 1'b1;
            state_d = StDone;
         end
         StDone: ;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         sign_q  <= 1'b0;
         exp_q   <= '0;
         big_q   <= '0;
         sml_q   <= '0;
         sub_q   <= 1'b0;
         sum_q   <= '0;
         res_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sign_q  <= sign_d;
         exp_q   <= exp_d;
         big_q   <= big_d;
         sml_q   <= sml_d;
         sub_q   <= sub_d;
         sum_q   <= sum_d;
         res_q   <= res_d;
         done_q  <= done_d;
      end
   end

   assign done = done_q;

endmodule

// File: tb/tb_flt_flt.sv
// Directed bench for flt_flt: preloads operands during reset and checks the stored sum.
module tb_flt_flt;

   logic clk;
   logic reset;
   logic done;

   int n_checks;
   int n_errors;

   flt_flt dut (
      .clk  (clk),
      .reset(reset),
      .done (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic load_ops(input logic [15:0] a, input logic [15:0] b);
      dut.data_mem1.my_memory[128] = a[15:8];
      dut.data_mem1.my_memory[129] = a[7:0];
      dut.data_mem1.my_memory[130] = b[15:8];
      dut.data_mem1.my_memory[131] = b[7:0];
      dut.data_mem1.my_memory[132] = 8'hA5;
      dut.data_mem1.my_memory[133] = 8'h5A;
   endtask

   function automatic logic [15:0] read_res();
      return {dut.data_mem1.my_memory[132], dut.data_mem1.my_memory[133]};
   endfunction

   task automatic wait_done(output int cycles);
      cycles = 0;
      while (!done && cycles < 20) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   // Assert reset between clock edges so done must fall without a clock.
   task automatic assert_reset(input string tag);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check_eq({tag, "_done_in_reset"}, {15'd0, done}, 16'd0);
   endtask

   task automatic run_case(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] r);
      int cyc;
      assert_reset(tag);
      load_ops(a, b);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      wait_done(cyc);
      check_eq({tag, "_latency"}, {15'd0, (done && cyc <= 16)}, 16'd1);
      check_eq({tag, "_result"}, read_res(), r);
      repeat (4) @(negedge clk);
      check_eq({tag, "_done_held"}, {15'd0, done}, 16'd1);
      check_eq({tag, "_result_held"}, read_res(), r);
   endtask

   logic [15:0] va [10];
   logic [15:0] vb [10];
   logic [15:0] vr [10];

   initial begin
      int cyc;
      n_checks = 0;
      n_errors = 0;
      reset    = 1'b0;

      va[0] = 16'h1A04; vb[0] = 16'h1A04; vr[0] = 16'h1E04;
      va[1] = 16'h4204; vb[1] = 16'h4204; vr[1] = 16'h4604;
      va[2] = 16'h4A10; vb[2] = 16'h4204; vr[2] = 16'h4B91;
      va[3] = 16'h4204; vb[3] = 16'h4A10; vr[3] = 16'h4B91;
      va[4] = 16'h520F; vb[4] = 16'h4204; vr[4] = 16'h526F;
      va[5] = 16'h4A10; vb[5] = 16'hC204; vr[5] = 16'h488F;
      va[6] = 16'hC204; vb[6] = 16'h4A10; vr[6] = 16'h488F;
      va[7] = 16'h4204; vb[7] = 16'hC204; vr[7] = 16'h0000;
      va[8] = 16'h7FFF; vb[8] = 16'h7FFF; vr[8] = 16'h7FFF;
      va[9] = 16'h0400; vb[9] = 16'h83FF; vr[9] = 16'h0000;

      repeat (2) @(negedge clk);
      check_eq("reset_done", {15'd0, done}, 16'd0);

      for (int i = 0; i < 10; i++) begin
         run_case($sformatf("case%0d", i), va[i], vb[i], vr[i]);
      end
      run_case("negneg", 16'hC204, 16'hC204, 16'hC604);

      // Abort mid-operation, before any result byte is written, then rerun.
      assert_reset("abort_pre");
      load_ops(16'h4A10, 16'h4204);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (5) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check_eq("abort_done", {15'd0, done}, 16'd0);
      repeat (3) @(negedge clk);
      check_eq("abort_no_write", read_res(), 16'hA55A);
      reset = 1'b1;
      wait_done(cyc);
      check_eq("abort_rerun_latency", {15'd0, (done && cyc <= 16)}, 16'd1);
      check_eq("abort_rerun_result", read_res(), 16'h4B91);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule
